// File: rtl/i2c_wr_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_wr_sequencer_if: command handshake and I2C-core bus signals   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface i2c_wr_sequencer_if;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [6:0] cmd_dev_i;
  logic [7:0] cmd_reg_i;
  logic [7:0] cmd_data_i;
  logic       done_o;
  logic       nack_o;
  logic       busy_o;
  logic [2:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i;
  logic       m_we_o;
  logic       m_stb_o;
  logic       m_ack_i;

  // Sequencer side.
  modport master (
    input  cmd_valid_i, cmd_dev_i, cmd_reg_i, cmd_data_i, m_dat_i, m_ack_i,
    output cmd_ready_o, done_o, nack_o, busy_o, m_adr_o, m_dat_o, m_we_o, m_stb_o
  );

  // Command source and I2C core side.
  modport slave (
    output cmd_valid_i, cmd_dev_i, cmd_reg_i, cmd_data_i, m_dat_i, m_ack_i,
    input  cmd_ready_o, done_o, nack_o, busy_o, m_adr_o, m_dat_o, m_we_o, m_stb_o
  );
endinterface
`default_nettype wire

// File: rtl/i2c_wr_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_wr_sequencer: initialises an I2C master core, then issues    |
// | START/dev/reg/data/STOP register writes. Rev 1.0                 |
// +------------------------------------------------------------------+
module i2c_wr_sequencer #(
  parameter logic [15:0] PRESCALE = 16'h0063
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  i2c_wr_sequencer_if.master     bus
);

  typedef enum logic [3:0] {
    INIT_PL   = 4'd0,
    INIT_PH   = 4'd1,
    INIT_CTR  = 4'd2,
    IDLE      = 4'd3,
    TX_DEV    = 4'd4,
    CR_DEV    = 4'd5,
    POLL_DEV  = 4'd6,
    TX_REG    = 4'd7,
    CR_REG    = 4'd8,
    POLL_REG  = 4'd9,
    TX_DAT    = 4'd10,
    CR_DAT    = 4'd11,
    POLL_DAT  = 4'd12,
    STOP      = 4'd13,
    POLL_STOP = 4'd14
  } state_t;

  state_t     state_q, state_d;
  logic       stb_q, stb_d;
  logic       we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] wdat_q, wdat_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       nack_q, nack_d;

  logic [2:0] acc_adr;
  logic [7:0] acc_dat;
  logic       acc_we;
  logic       sr_tip;
  logic       sr_fail;

  // RxACK and arbitration-lost both abort the transfer.
  assign sr_tip  = bus.m_dat_i[1];
  assign sr_fail = |(bus.m_dat_i & 8'hA0);

  always_comb begin
    acc_adr = 3'd4;
    acc_dat = 8'h00;
    acc_we  = 1'b1;
    case (state_q)
      INIT_PL:   begin acc_adr = 3'd0; acc_dat = PRESCALE[7:0];  end
      INIT_PH:   begin acc_adr = 3'd1; acc_dat = PRESCALE[15:8]; end
      INIT_CTR:  begin acc_adr = 3'd2; acc_dat = 8'h80;          end
      TX_DEV:    begin acc_adr = 3'd3; acc_dat = {dev_q, 1'b0};  end
      CR_DEV:    acc_dat = 8'h90;
      TX_REG:    begin acc_adr = 3'd3; acc_dat = reg_q;          end
      CR_REG:    acc_dat = 8'h10;
      TX_DAT:    begin acc_adr = 3'd3; acc_dat = data_q;         end
      CR_DAT:    acc_dat = 8'h50;
      STOP:      acc_dat = 8'h40;
      POLL_DEV, POLL_REG, POLL_DAT, POLL_STOP: acc_we = 1'b0;
      default:   acc_we = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    nack_d  = nack_q;

    if (state_q == IDLE) begin
      if (bus.cmd_valid_i && !done_q) begin
        dev_d   = bus.cmd_dev_i;
        reg_d   = bus.cmd_reg_i;
        data_d  = bus.cmd_data_i;
        state_d = TX_DEV;
      end
    end else if (!stb_q) begin
      // Strobe is raised only from a low cycle, which guarantees the idle gap.
      stb_d  = 1'b1;
      adr_d  = acc_adr;
      we_d   = acc_we;
      wdat_d = acc_dat;
    end else if (bus.m_ack_i) begin
      stb_d = 1'b0;
      we_d  = 1'b0;
      case (state_q)
        INIT_PL:   state_d = INIT_PH;
        INIT_PH:   state_d = INIT_CTR;
        INIT_CTR:  state_d = IDLE;
        TX_DEV:    state_d = CR_DEV;
        CR_DEV:    state_d = POLL_DEV;
        POLL_DEV:  if (!sr_tip) state_d = sr_fail ? STOP : TX_REG;
        TX_REG:    state_d = CR_REG;
        CR_REG:    state_d = POLL_REG;
        POLL_REG:  if (!sr_tip) state_d = sr_fail ? STOP : TX_DAT;
        TX_DAT:    state_d = CR_DAT;
        CR_DAT:    state_d = POLL_DAT;
        POLL_DAT: begin
          if (!sr_tip) begin
            state_d = IDLE;
            done_d  = 1'b1;
            nack_d  = sr_fail;
          end
        end
        STOP:      state_d = POLL_STOP;
        POLL_STOP: begin
          if (!sr_tip) begin
            state_d = IDLE;
            done_d  = 1'b1;
            nack_d  = 1'b1;
          end
        end
        default:   state_d = INIT_PL;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= INIT_PL;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      wdat_q  <= 8'h00;
      dev_q   <= 7'd0;
      reg_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  // Ready is held off during the done cycle so a held cmd_valid_i starts
  // the next command strictly after the completion pulse.
  assign bus.cmd_ready_o = (state_q == IDLE) && !done_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = done_q;
  assign bus.nack_o      = nack_q;
  assign bus.m_stb_o     = stb_q;
  assign bus.m_we_o      = we_q;
  assign bus.m_adr_o     = adr_q;
  assign bus.m_dat_o     = wdat_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_wr_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_i2c_wr_sequencer: I2C-core slave model plus command reference |
// | model for i2c_wr_sequencer. Rev 1.0                              |
// +------------------------------------------------------------------+
module tb_i2c_wr_sequencer;
  localparam logic [15:0] C_PRESCALE = 16'h0063;
  localparam logic [11:0] C_RD       = {1'b0, 3'd4, 8'h00};

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  i2c_wr_sequencer_if bus ();
  i2c_wr_sequencer #(.PRESCALE(C_PRESCALE)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] log_q [$];
  logic [11:0] exp_q [$];
  logic [7:0]  sr_q  [$];
  int lat       = 2;
  int glitch_en = 0;
  int viol      = 0;
  int done_cnt  = 0;
  int done_wide = 0;
  logic last_nack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // I2C core model: acks each access after `lat` cycles, returns SR from sr_q,
  // logs every access and counts protocol violations.
  initial begin
    logic [11:0] held;
    logic [11:0] cur;
    logic        acked_prev;
    int          cnt;
    bus.m_ack_i = 1'b0;
    bus.m_dat_i = 8'h00;
    held = '0;
    acked_prev = 1'b0;
    cnt = 0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        bus.m_ack_i = 1'b0;
        cnt = 0;
        acked_prev = 1'b0;
      end else if (bus.m_stb_o) begin
        if (acked_prev) viol++;
        cur = {bus.m_we_o, bus.m_adr_o, bus.m_dat_o};
        if (cnt == 0) held = cur;
        else if (cur !== held) viol++;
        cnt++;
        acked_prev = 1'b0;
        if (cnt >= lat) begin
          bus.m_ack_i = 1'b1;
          if (bus.m_we_o) log_q.push_back(cur);
          else begin
            bus.m_dat_i = (sr_q.size() != 0) ? sr_q.pop_front() : 8'h00;
            log_q.push_back(C_RD);
          end
          acked_prev = 1'b1;
          cnt = 0;
        end else begin
          bus.m_ack_i = 1'b0;
        end
      end else begin
        cnt = 0;
        acked_prev = 1'b0;
        bus.m_ack_i = (glitch_en != 0) && ($urandom_range(0, 2) == 0);
        bus.m_dat_i = 8'($urandom);
      end
    end
  end

  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (bus.done_o) begin
        done_cnt++;
        last_nack = bus.nack_o;
        if (done_prev) done_wide++;
      end
      done_prev = bus.done_o;
    end
  end

  // Reference: expected access list and SR script for one command.
  task automatic model_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dat,
                           input int b0, input int b1, input int b2, input int b3,
                           input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
                           output logic nack);
    logic [7:0] byt [3];
    logic [7:0] crv [3];
    logic [7:0] fin [3];
    int         bz  [3];
    byt[0] = {dev, 1'b0}; byt[1] = rg;    byt[2] = dat;
    crv[0] = 8'h90;       crv[1] = 8'h10; crv[2] = 8'h50;
    fin[0] = f0;          fin[1] = f1;    fin[2] = f2;
    bz[0]  = b0;          bz[1]  = b1;    bz[2]  = b2;
    nack = 1'b0;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back({1'b1, 3'd3, byt[p]});
      exp_q.push_back({1'b1, 3'd4, crv[p]});
      for (int k = 0; k < bz[p]; k++) begin
        exp_q.push_back(C_RD);
        sr_q.push_back(8'($urandom) | 8'h02);
      end
      exp_q.push_back(C_RD);
      sr_q.push_back(fin[p]);
      if (fin[p][7] || fin[p][5]) begin
        nack = 1'b1;
        if (p < 2) begin
          exp_q.push_back({1'b1, 3'd4, 8'h40});
          for (int k = 0; k < b3; k++) begin
            exp_q.push_back(C_RD);
            sr_q.push_back(8'($urandom) | 8'h02);
          end
          exp_q.push_back(C_RD);
          sr_q.push_back(8'($urandom) & 8'hFD);
        end
        break;
      end
    end
  endtask

  function automatic logic [7:0] fin_ok();
    return 8'($urandom) & 8'h5D;
  endfunction

  function automatic logic [7:0] fin_bad();
    return (8'($urandom) & 8'h5D) | (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h20);
  endfunction

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    @(negedge wb_clk_i);
    while (!bus.cmd_ready_o && t < 500) begin
      @(negedge wb_clk_i);
      t++;
    end
    check({tag, "_ready"}, 32'(bus.cmd_ready_o), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 4000) begin
      @(negedge wb_clk_i);
      t++;
    end
    check({tag, "_done"}, done_cnt, target);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_acc%0d", tag, i), log_q[i], exp_q[i]);
      if (log_q[i] !== exp_q[i]) break;
    end
    check({tag, "_proto"}, viol, 0);
    check({tag, "_done_width"}, done_wide, 0);
  endtask

  task automatic expect_init(input string tag);
    exp_q.delete();
    exp_q.push_back({1'b1, 3'd0, C_PRESCALE[7:0]});
    exp_q.push_back({1'b1, 3'd1, C_PRESCALE[15:8]});
    exp_q.push_back({1'b1, 3'd2, 8'h80});
    wait_ready(tag);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    compare_log(tag);
  endtask

  task automatic do_cmd(input string tag, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] dat, input int b0, input int b1, input int b2,
                        input int b3, input logic [7:0] f0, input logic [7:0] f1,
                        input logic [7:0] f2);
    logic exp_nack;
    int   d0;
    log_q.delete(); exp_q.delete(); sr_q.delete();
    model_cmd(dev, rg, dat, b0, b1, b2, b3, f0, f1, f2, exp_nack);
    d0 = done_cnt;
    wait_ready(tag);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_dev_i   = dev;
    bus.cmd_reg_i   = rg;
    bus.cmd_data_i  = dat;
    @(posedge wb_clk_i);
    #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_dev_i   = 7'($urandom);
    bus.cmd_reg_i   = 8'($urandom);
    bus.cmd_data_i  = 8'($urandom);
    wait_done(tag, d0 + 1);
    check({tag, "_nack"}, 32'(last_nack), 32'(exp_nack));
    repeat (4) @(negedge wb_clk_i);
    check({tag, "_nack_hold"}, 32'(bus.nack_o), 32'(exp_nack));
    check({tag, "_done_low"}, 32'(bus.done_o), 32'd0);
    check({tag, "_done_cnt"}, done_cnt, d0 + 1);
    compare_log(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic n_a, n_b;
    int   d0, t;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_dev_i   = '0;
    bus.cmd_reg_i   = '0;
    bus.cmd_data_i  = '0;

    #2 wb_rst_i = 1'b1;
    #1;
    check("rst_stb",   32'(bus.m_stb_o),     32'd0);
    check("rst_we",    32'(bus.m_we_o),      32'd0);
    check("rst_adr",   32'(bus.m_adr_o),     32'd0);
    check("rst_dat",   32'(bus.m_dat_o),     32'd0);
    check("rst_ready", 32'(bus.cmd_ready_o), 32'd0);
    check("rst_done",  32'(bus.done_o),      32'd0);
    check("rst_nack",  32'(bus.nack_o),      32'd0);
    check("rst_busy",  32'(bus.busy_o),      32'd1);
    repeat (3) @(negedge wb_clk_i);
    log_q.delete();
    wb_rst_i = 1'b0;
    lat = 2;
    expect_init("init");

    do_cmd("basic", 7'h4C, 8'h12, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    do_cmd("tip5",  7'h21, 8'h34, 8'h56, 5, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    do_cmd("devnak", 7'h4C, 8'h12, 8'hA5, 0, 0, 0, 1, 8'h80, 8'h00, 8'h00);
    do_cmd("reg_al", 7'h11, 8'h22, 8'h33, 1, 2, 0, 2, 8'h00, 8'h20, 8'h00);
    do_cmd("datnak", 7'h7F, 8'hFF, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00, 8'h80);

    // Two commands behind one continuously held cmd_valid_i.
    glitch_en = 1;
    log_q.delete(); exp_q.delete(); sr_q.delete();
    model_cmd(7'h15, 8'hC3, 8'h3C, 1, 0, 2, 0, 8'h00, 8'h00, 8'h00, n_a);
    model_cmd(7'h6A, 8'h5A, 8'hA5, 0, 1, 0, 1, 8'h00, 8'h80, 8'h00, n_b);
    d0 = done_cnt;
    wait_ready("hold");
    bus.cmd_valid_i = 1'b1;
    bus.cmd_dev_i = 7'h15; bus.cmd_reg_i = 8'hC3; bus.cmd_data_i = 8'h3C;
    t = 0;
    do begin @(negedge wb_clk_i); t++; end while (!bus.busy_o && t < 100);
    bus.cmd_dev_i = 7'h6A; bus.cmd_reg_i = 8'h5A; bus.cmd_data_i = 8'hA5;
    wait_done("hold_a", d0 + 1);
    check("hold_a_nack", 32'(last_nack), 32'(n_a));
    t = 0;
    while (!bus.busy_o && t < 100) begin @(negedge wb_clk_i); t++; end
    bus.cmd_valid_i = 1'b0;
    wait_done("hold_b", d0 + 2);
    check("hold_b_nack", 32'(last_nack), 32'(n_b));
    repeat (3) @(negedge wb_clk_i);
    compare_log("hold");

    for (int i = 0; i < 10; i++) begin
      logic [7:0] f [3];
      lat = $urandom_range(1, 3);
      for (int p = 0; p < 3; p++) f[p] = ($urandom_range(0, 4) == 0) ? fin_bad() : fin_ok();
      do_cmd($sformatf("rnd%0d", i), 7'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), f[0], f[1], f[2]);
    end

    // Reset in the middle of the register-byte poll.
    glitch_en = 0;
    lat = 2;
    log_q.delete(); exp_q.delete(); sr_q.delete();
    model_cmd(7'h4C, 8'h12, 8'hA5, 0, 10, 0, 0, 8'h00, 8'h00, 8'h00, n_a);
    wait_ready("mid");
    bus.cmd_valid_i = 1'b1;
    bus.cmd_dev_i = 7'h4C; bus.cmd_reg_i = 8'h12; bus.cmd_data_i = 8'hA5;
    @(posedge wb_clk_i);
    #1 bus.cmd_valid_i = 1'b0;
    t = 0;
    while (log_q.size() < 7 && t < 200) begin @(negedge wb_clk_i); #1; t++; end
    check("mid_reached_poll", log_q.size(), 7);
    d0 = done_cnt;
    #2 wb_rst_i = 1'b1;
    #1;
    check("mid_stb", 32'(bus.m_stb_o), 32'd0);
    check("mid_busy", 32'(bus.busy_o), 32'd1);
    repeat (3) @(negedge wb_clk_i);
    log_q.delete(); sr_q.delete();
    wb_rst_i = 1'b0;
    expect_init("reinit");
    repeat (5) @(negedge wb_clk_i);
    check("mid_no_done", done_cnt, d0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
